serial_nibble_subtractor: RTL and testbench

// - Multi-cycle ANCHO-bit subtractor: aluresult = a - b - aluflagin (aluflagin = borrow in).
// - Processes one 4-bit slice per clock, LSB nibble first, through a 4-bit borrow-lookahead slice.
// - Borrow is registered between slices.
// - Inverse datapath of the 4-bit carry-lookahead adder; sits beside it in the ALU for SUB/CMP ops.

---
 rtl/alu_pkg.sv | 19 +
 rtl/sub_4bits.sv | 39 +++
 rtl/serial_nibble_subtractor.sv | 151 +++++++++++++++
 tb/tb_serial_nibble_subtractor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared slice width and FSM state encoding for the serial
//               nibble subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sub_4bits.sv
`default_nettype none
// ============================================================================
// Module      : sub_4bits
// Description : Combinational 4-bit borrow-lookahead subtractor slice.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_4bits
    import alu_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              bin,
    output logic [NIBBLE-1:0] d,
    output logic              bout
);

    logic [NIBBLE-1:0] w_g;
    logic [NIBBLE-1:0] w_p;
    logic [NIBBLE:0]   w_c;

    // A bit generates a borrow when it is 0 against a 1, and passes an
    // incoming borrow through when both bits are equal.
    assign w_g = ~a & b;
    assign w_p = ~(a ^ b);

    assign w_c[0] = bin;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign d    = a ^ b ^ w_c[NIBBLE-1:0];
    assign bout = w_c[NIBBLE];

endmodule
`default_nettype wire

// File: rtl/serial_nibble_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_nibble_subtractor
// Description : Multi-cycle a - b - borrow_in, one nibble per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_nibble_subtractor
    import alu_pkg::*;
#(
    parameter int ANCHO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic             aluflagin,
    output logic [ANCHO-1:0] aluresult,
    output logic             aluflags,
    output logic             ovfflag,
    output logic             zeroflag,
    output logic             done
);

    localparam int c_nslice = ANCHO / NIBBLE;
    localparam int c_idxw   = $clog2(c_nslice);
    localparam int c_offw   = c_idxw + 2;

    generate
        if ((ANCHO % NIBBLE) != 0 || ANCHO < 8) begin : g_ancho_check
            $error("ANCHO must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t              r_state_q,     w_state_d;
    logic [c_idxw-1:0]   r_idx_q,       w_idx_d;
    logic [ANCHO-1:0]    r_a_q,         w_a_d;
    logic [ANCHO-1:0]    r_b_q,         w_b_d;
    logic                r_borrow_q,    w_borrow_d;
    logic [ANCHO-1:0]    r_res_q,       w_res_d;
    logic [ANCHO-1:0]    r_aluresult_q, w_aluresult_d;
    logic                r_aluflags_q,  w_aluflags_d;
    logic                r_ovf_q,       w_ovf_d;
    logic                r_zero_q,      w_zero_d;

    logic [c_offw-1:0]   w_off;
    logic [NIBBLE-1:0]   w_nib_d;
    logic                w_nib_bout;
    logic [ANCHO-1:0]    w_res_upd;
    logic                w_last;
    logic                w_ovf;

    assign w_off  = {r_idx_q, 2'b00};
    assign w_last = (r_idx_q == c_idxw'(c_nslice - 1));

    sub_4bits u_slice (
        .a    (r_a_q[w_off +: NIBBLE]),
        .b    (r_b_q[w_off +: NIBBLE]),
        .bin  (r_borrow_q),
        .d    (w_nib_d),
        .bout (w_nib_bout)
    );

    always_comb begin
        w_res_upd                   = r_res_q;
        w_res_upd[w_off +: NIBBLE]  = w_nib_d;
    end

    // Only meaningful on the top slice: operand signs differ and the result
    // sign disagrees with the minuend.
    assign w_ovf = (r_a_q[ANCHO-1] != r_b_q[ANCHO-1]) &&
                   (w_nib_d[NIBBLE-1] != r_a_q[ANCHO-1]);

    always_comb begin
        w_state_d     = r_state_q;
        w_idx_d       = r_idx_q;
        w_a_d         = r_a_q;
        w_b_d         = r_b_q;
        w_borrow_d    = r_borrow_q;
        w_res_d       = r_res_q;
        w_aluresult_d = r_aluresult_q;
        w_aluflags_d  = r_aluflags_q;
        w_ovf_d       = r_ovf_q;
        w_zero_d      = r_zero_q;
        case (r_state_q)
            IDLE, DONE: begin
                if (valid_in) begin
                    w_a_d      = a;
                    w_b_d      = b;
                    w_borrow_d = aluflagin;
                    w_res_d    = '0;
                    w_idx_d    = '0;
                    w_state_d  = RUN;
                end else if (r_state_q == DONE) begin
                    w_state_d = IDLE;
                end
            end
            RUN: begin
                w_res_d    = w_res_upd;
                w_borrow_d = w_nib_bout;
                if (w_last) begin
                    w_idx_d       = '0;
                    w_state_d     = DONE;
                    w_aluresult_d = w_res_upd;
                    w_aluflags_d  = w_nib_bout;
                    w_ovf_d       = w_ovf;
                    w_zero_d      = (w_res_upd == '0);
                end else begin
                    w_idx_d = r_idx_q + c_idxw'(1);
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_idx_q       <= '0;
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_borrow_q    <= 1'b0;
            r_res_q       <= '0;
            r_aluresult_q <= '0;
            r_aluflags_q  <= 1'b0;
            r_ovf_q       <= 1'b0;
            r_zero_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_idx_q       <= w_idx_d;
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_borrow_q    <= w_borrow_d;
            r_res_q       <= w_res_d;
            r_aluresult_q <= w_aluresult_d;
            r_aluflags_q  <= w_aluflags_d;
            r_ovf_q       <= w_ovf_d;
            r_zero_q      <= w_zero_d;
        end
    end

    assign ready     = (r_state_q != RUN);
    assign done      = (r_state_q == DONE);
    assign aluresult = r_aluresult_q;
    assign aluflags  = r_aluflags_q;
    assign ovfflag   = r_ovf_q;
    assign zeroflag  = r_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_nibble_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_nibble_subtractor
// Description : Directed and random self-checking bench, ANCHO=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_nibble_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         aluflagin;
    logic [W-1:0] aluresult;
    logic         aluflags;
    logic         ovfflag;
    logic         zeroflag;
    logic         done;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] last_res;

    serial_nibble_subtractor #(.ANCHO(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .ready     (ready),
        .a         (a),
        .b         (b),
        .aluflagin (aluflagin),
        .aluresult (aluresult),
        .aluflags  (aluflags),
        .ovfflag   (ovfflag),
        .zeroflag  (zeroflag),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] res,
                             input logic fl, input logic ov, input logic zr);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_res"},  {16'd0, aluresult}, {16'd0, res});
        chk({tag, "_borrow"}, {31'd0, aluflags}, {31'd0, fl});
        chk({tag, "_ovf"},  {31'd0, ovfflag}, {31'd0, ov});
        chk({tag, "_zero"}, {31'd0, zeroflag}, {31'd0, zr});
    endtask

    // Drive a request ahead of the edge; returns 1ns after the accepting edge.
    task automatic start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        @(negedge clk);
        a = ta; b = tb; aluflagin = tbin; valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        chk("ready_low_in_run", {31'd0, ready}, 32'd0);
    endtask

    // Counts edges until done; the visible result must hold meanwhile.
    task automatic wait_done(input logic [W-1:0] hold, output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            chk("hold_result", {16'd0, aluresult}, {16'd0, hold});
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input logic [W-1:0] res,
                          input logic fl, input logic ov, input logic zr);
        int lat;
        start(ta, tb, tbin);
        wait_done(last_res, lat);
        // Accept at edge E, done visible after edge E+4 for four slices.
        chk({tag, "_latency"}, lat, 32'd4);
        check_out(tag, res, fl, ov, zr);
        last_res = res;
    endtask

    initial begin
        int lat;
        int nd;
        logic [W-1:0] ra, rb, rd;
        logic         rbin, rbo, rov;
        logic [W:0]   full;

        rst = 1'b1; valid_in = 1'b0; a = '0; b = '0; aluflagin = 1'b0;
        last_res = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", {16'd0, aluresult}, 32'd0);
        chk("rst_flags", {29'd0, aluflags, ovfflag, zeroflag}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("sub_1234", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("ready_after_done", {31'd0, ready}, 32'd1);

        run_op("ripple", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        run_op("ovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("zero_bin", 16'h0100, 16'h00FF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        run_op("eq_bin", 16'h5A5A, 16'h5A5A, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Back-to-back: new request presented during the DONE cycle.
        start(16'h0005, 16'h0003, 1'b0);
        wait_done(last_res, lat);
        chk("b2b_first_latency", lat, 32'd4);
        a = 16'h0010; b = 16'h0001; aluflagin = 1'b0; valid_in = 1'b1;
        check_out("b2b_first", 16'h0002, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        chk("b2b_accepted", {31'd0, ready}, 32'd0);
        chk("b2b_done_low", {31'd0, done}, 32'd0);
        wait_done(16'h0002, lat);
        chk("b2b_second_latency", lat, 32'd4);
        check_out("b2b_second", 16'h000F, 1'b0, 1'b0, 1'b0);
        last_res = 16'h000F;

        // A request and operand change during RUN must be ignored.
        start(16'h00F0, 16'h000F, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; aluflagin = 1'b1; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        wait_done(last_res, lat);
        chk("ignore_latency", lat, 32'd3);
        check_out("ignore", 16'h00E1, 1'b0, 1'b0, 1'b0);
        last_res = 16'h00E1;
        nd = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("ignore_no_extra_done", nd, 32'd0);

        // Reset while slice k=2 is being computed.
        start(16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_res", {16'd0, aluresult}, 32'd0);
        chk("abort_flags", {29'd0, aluflags, ovfflag, zeroflag}, 32'd0);
        rst = 1'b0;
        nd = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("abort_no_done", nd, 32'd0);
        last_res = '0;
        run_op("after_abort", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            rd   = full[W-1:0];
            rbo  = full[W];
            rov  = (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]);
            run_op("rand", ra, rb, rbin, rd, rbo, rov, (rd == '0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
